// File: rtl/cc_pkg.sv
// cc_pkg: flag bit positions, ARM condition encodings and FSM state encoding
// shared by the condition-code controller and its condition evaluator.
package cc_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_EXC    = 2'd1,
        ST_RET    = 2'd2
    } state_e;

endpackage

// File: rtl/cc_cond_eval.sv
// cc_cond_eval: combinational ARM condition-field evaluation against a flag nibble.
module cc_cond_eval
    import cc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       true
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        true = 1'b0;
        case (cond_e'(cond))
            COND_EQ: true = z;
            COND_NE: true = ~z;
            COND_CS: true = c;
            COND_CC: true = ~c;
            COND_MI: true = n;
            COND_PL: true = ~n;
            COND_VS: true = v;
            COND_VC: true = ~v;
            COND_HI: true = c & ~z;
            COND_LS: true = ~c | z;
            COND_GE: true = n == v;
            COND_LT: true = n != v;
            COND_GT: true = ~z & (n == v);
            COND_LE: true = z | (n != v);
            COND_AL: true = 1'b1;
            default: true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_controller.sv
// cc_controller: committed condition flags with exception save/restore FSM,
// protocol-error tracking and ID-stage condition evaluation.
module cc_controller
    import cc_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       alu_we,
    input  logic [3:0] alu_cc,
    input  logic       msr_we,
    input  logic [3:0] msr_cc,
    input  logic       flush,
    input  logic       exc_entry,
    input  logic       exc_return,
    input  logic [3:0] cond,
    output logic [3:0] cc_out,
    output logic [3:0] shadow_out,
    output logic       cond_true,
    output logic       stall,
    output logic       in_exc,
    output logic       err
);

    state_e     state_q;
    logic [3:0] cc_q;
    logic [3:0] shadow_q;
    logic       err_q;
    logic       both;
    logic       wr_en;
    logic [3:0] wr_val;

    assign both   = exc_entry & exc_return;
    // Software writes win over the ALU; flush only squashes the ALU update.
    assign wr_en  = msr_we | (alu_we & ~flush);
    assign wr_val = msr_we ? msr_cc : alu_cc;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q  <= ST_NORMAL;
            cc_q     <= 4'h0;
            shadow_q <= 4'h0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (both) begin
                        err_q <= 1'b1;
                    end else if (exc_entry) begin
                        shadow_q <= cc_q;
                        state_q  <= ST_EXC;
                    end else begin
                        if (exc_return) err_q <= 1'b1;
                        if (wr_en) cc_q <= wr_val;
                    end
                end
                ST_EXC: begin
                    if (both) begin
                        err_q <= 1'b1;
                    end else if (exc_return) begin
                        cc_q    <= shadow_q;
                        state_q <= ST_RET;
                    end else begin
                        if (exc_entry) err_q <= 1'b1;
                        if (wr_en) cc_q <= wr_val;
                    end
                end
                ST_RET: begin
                    if (exc_entry | exc_return) err_q <= 1'b1;
                    state_q <= ST_NORMAL;
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

    // Stall also covers the accept cycle so ID never sees stale flags mid-restore.
    assign stall      = (state_q == ST_RET) | ((state_q == ST_EXC) & exc_return & ~exc_entry);
    assign in_exc     = state_q == ST_EXC;
    assign cc_out     = cc_q;
    assign shadow_out = shadow_q;
    assign err        = err_q;

    cc_cond_eval u_cond_eval (
        .cond  (cond),
        .flags (cc_q),
        .true  (cond_true)
    );

endmodule

// File: tb/tb_cc_controller.sv
// tb_cc_controller: directed sequences, condition table/sweep and randomized
// checking against a behavioural flag/exception model.
module tb_cc_controller;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       alu_we, msr_we, flush, exc_entry, exc_return;
    logic [3:0] alu_cc, msr_cc, cond;
    logic [3:0] cc_out, shadow_out;
    logic       cond_true, stall, in_exc, err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cc_controller dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .alu_we     (alu_we),
        .alu_cc     (alu_cc),
        .msr_we     (msr_we),
        .msr_cc     (msr_cc),
        .flush      (flush),
        .exc_entry  (exc_entry),
        .exc_return (exc_return),
        .cond       (cond),
        .cc_out     (cc_out),
        .shadow_out (shadow_out),
        .cond_true  (cond_true),
        .stall      (stall),
        .in_exc     (in_exc),
        .err        (err)
    );

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       exp;
    } vec_t;

    vec_t tbl [8];

    // Reference condition evaluator: ARM pairs share a base predicate, odd codes invert it.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, b;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cy;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cy & ~z;
            3'd5: b = (n == v);
            3'd6: b = ~z & (n == v);
            default: b = 1'b1;
        endcase
        return b ^ c[0];
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        alu_we = 0; msr_we = 0; flush = 0; exc_entry = 0; exc_return = 0;
        alu_cc = 0; msr_cc = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RSTn = 0;
        tick();
        RSTn = 1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        idle(); msr_we = 1; msr_cc = f;
        tick();
        idle();
    endtask

    // Behavioural model state: 0 normal, 1 in exception, 2 returning
    int         m_st;
    logic [3:0] m_cc, m_sh;
    logic       m_err;

    task automatic model_step();
        if (!RSTn) begin
            m_st = 0; m_cc = 0; m_sh = 0; m_err = 0;
        end else if (m_st == 2) begin
            if (exc_entry || exc_return) m_err = 1;
            m_st = 0;
        end else if (exc_entry && exc_return) begin
            m_err = 1;
        end else if (m_st == 0 && exc_entry) begin
            m_sh = m_cc; m_st = 1;
        end else if (m_st == 1 && exc_return) begin
            m_cc = m_sh; m_st = 2;
        end else begin
            if (exc_entry || exc_return) m_err = 1;
            if (msr_we) m_cc = msr_cc;
            else if (alu_we && !flush) m_cc = alu_cc;
        end
    endtask

    initial begin
        idle();
        cond = 0;
        RSTn = 0;
        tick();
        // Reset overrides a same-cycle request
        msr_we = 1; msr_cc = 4'hF; exc_entry = 1;
        tick();
        idle();
        chk("reset cc_out", cc_out, 4'h0);
        chk("reset shadow", shadow_out, 4'h0);
        chk("reset in_exc", in_exc, 0);
        chk("reset err", err, 0);
        chk("reset stall", stall, 0);
        RSTn = 1;

        // ALU write, no same-cycle bypass
        alu_we = 1; alu_cc = 4'b0100; cond = 4'b0000;
        #1;
        chk("no bypass", cond_true, 0);
        tick();
        idle();
        chk("alu write", cc_out, 4'b0100);
        chk("EQ after write", cond_true, 1);

        // msr beats alu; flush kills only alu
        alu_we = 1; alu_cc = 4'b1000; msr_we = 1; msr_cc = 4'b0011;
        tick(); idle();
        chk("msr priority", cc_out, 4'b0011);
        alu_we = 1; alu_cc = 4'hF; flush = 1;
        tick(); idle();
        chk("flush alu", cc_out, 4'b0011);
        msr_we = 1; msr_cc = 4'b1001; flush = 1;
        tick(); idle();
        chk("flush keeps msr", cc_out, 4'b1001);

        // Exception entry drops same-cycle ALU write
        exc_entry = 1; alu_we = 1; alu_cc = 4'b0000;
        tick(); idle();
        chk("entry shadow", shadow_out, 4'b1001);
        chk("entry cc hold", cc_out, 4'b1001);
        chk("entry in_exc", in_exc, 1);
        msr_we = 1; msr_cc = 4'b0110;
        tick(); idle();
        chk("exc msr", cc_out, 4'b0110);

        // Return: restore, stall for accept + RET cycles
        exc_return = 1; msr_we = 1; msr_cc = 4'hA;
        #1;
        chk("stall accept", stall, 1);
        tick(); idle();
        chk("return restore", cc_out, 4'b1001);
        chk("ret stall", stall, 1);
        chk("ret in_exc", in_exc, 0);
        msr_we = 1; msr_cc = 4'hF;
        tick(); idle();
        chk("ret ignores msr", cc_out, 4'b1001);
        chk("normal stall", stall, 0);
        chk("no err yet", err, 0);

        // Protocol errors
        exc_return = 1;
        tick(); idle();
        chk("stray return err", err, 1);
        chk("stray return state", in_exc, 0);
        set_flags(4'b0101);
        exc_entry = 1;
        tick(); idle();
        msr_we = 1; msr_cc = 4'b0111;
        tick(); idle();
        exc_entry = 1;
        tick(); idle();
        chk("nested shadow", shadow_out, 4'b0101);
        chk("nested err", err, 1);
        chk("nested in_exc", in_exc, 1);

        // Reset during RET discards restore path
        exc_return = 1;
        tick(); idle();
        RSTn = 0; msr_we = 1; msr_cc = 4'hC;
        tick(); idle(); RSTn = 1;
        chk("rst in RET cc", cc_out, 4'h0);
        chk("rst in RET shadow", shadow_out, 4'h0);
        chk("rst in RET stall", stall, 0);
        chk("rst in RET err", err, 0);

        // Simultaneous entry+return in EXC: no change, err set
        set_flags(4'h3);
        exc_entry = 1;
        tick(); idle();
        exc_entry = 1; exc_return = 1;
        #1;
        chk("both no stall", stall, 0);
        tick(); idle();
        chk("both in_exc", in_exc, 1);
        chk("both err", err, 1);
        chk("both cc", cc_out, 4'h3);

        // Condition table
        tbl[0] = '{4'b0100, 4'b0000, 1'b1};
        tbl[1] = '{4'b0000, 4'b0001, 1'b1};
        tbl[2] = '{4'b1001, 4'b1010, 1'b1};
        tbl[3] = '{4'b1000, 4'b1011, 1'b1};
        tbl[4] = '{4'b0010, 4'b1000, 1'b1};
        tbl[5] = '{4'b0110, 4'b1001, 1'b1};
        tbl[6] = '{4'b0000, 4'b1100, 1'b1};
        tbl[7] = '{4'b0000, 4'b1111, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_flags(tbl[i].flags);
            cond = tbl[i].cond;
            #1;
            chk($sformatf("tbl%0d", i), cond_true, tbl[i].exp);
        end

        // Full 16x16 sweep
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1;
                chk($sformatf("sweep c%0h f%0h", c, f), cond_true, ref_cond(4'(c), 4'(f)));
            end
        end

        // Randomized run against the model
        do_reset();
        m_st = 0; m_cc = 0; m_sh = 0; m_err = 0;
        for (int k = 0; k < 600; k++) begin
            RSTn       = ($urandom_range(0, 59) != 0);
            alu_we     = $urandom_range(0, 1) == 1;
            msr_we     = $urandom_range(0, 3) == 0;
            flush      = $urandom_range(0, 3) == 0;
            exc_entry  = $urandom_range(0, 7) == 0;
            exc_return = $urandom_range(0, 7) == 0;
            alu_cc     = 4'($urandom);
            msr_cc     = 4'($urandom);
            cond       = 4'($urandom);
            #1;
            if (RSTn) chk("rnd stall", stall, (m_st == 2) || (m_st == 1 && exc_return && !exc_entry));
            chk("rnd cond", cond_true, ref_cond(cond, m_cc));
            model_step();
            tick();
            chk("rnd cc", cc_out, m_cc);
            chk("rnd shadow", shadow_out, m_sh);
            chk("rnd in_exc", in_exc, m_st == 1);
            chk("rnd err", err, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
